// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - WIDTH-bit add/subtract sequenced through one 4-bit CLA slice
//
// Purpose: time-shares a single 4-bit carry-lookahead slice across a WIDTH-bit
// add or subtract, least significant nibble first, one nibble per clock.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request; accepted in IDLE or DONE
//   sub       0 = a+b, 1 = a-b (latched on acceptance)
//   a, b      WIDTH-bit operands (latched on acceptance)
//   busy      high while nibbles are being processed (RUN)
//   done      one-cycle pulse; result and flags valid from this cycle on
//   result    sum/difference, held until the next accepted start
//   cout      carry out of the MSB nibble (subtract: 1 = no borrow)
//   overflow  signed overflow
//   zero      result == 0
module nibble_serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;

    logic             accept;
    logic             last;

    logic [3:0]       nib_a, nib_b;
    logic [3:0]       g, p, c;
    logic             c4;
    logic [3:0]       sum;
    logic [WIDTH-1:0] res_upd;

    assign last = (idx_q == IW'(NIB - 1));

    // Slice operands: B is inverted for subtract; carry_q was seeded with sub
    // on acceptance, which completes the two's complement.
    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};

    // 4-bit carry-lookahead slice. c[3] is the carry into the slice MSB, which
    // on the top nibble is the carry into bit WIDTH-1.
    always_comb begin
        g    = nib_a & nib_b;
        p    = nib_a ^ nib_b;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        sum  = p ^ c;
    end

    // Result with the current nibble merged in; also feeds the zero flag so
    // zero is registered on the same edge that completes the result.
    always_comb begin
        res_upd = result;
        res_upd[{idx_q, 2'b00} +: 4] = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            sub_q    <= sub;
            idx_q    <= '0;
            carry_q  <= sub;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state_q == RUN) begin
            result  <= res_upd;
            carry_q <= c4;
            if (last) begin
                idx_q    <= '0;
                cout     <= c4;
                overflow <= c[3] ^ c4;
                zero     <= (res_upd == '0);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb/tb_nibble_serial_addsub.sv - directed and random checks of nibble_serial_addsub
module tb_nibble_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic [31:0] res32;

    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  res8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32),
        .overflow(ovf32), .zero(zero32)
    );

    nibble_serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8),
        .overflow(ovf8), .zero(zero8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents an operation at the current cycle (DUT in IDLE or DONE), then
    // waits for done and checks the 8-cycle latency and busy profile.
    task automatic go32(input logic [31:0] x, input logic [31:0] y, input logic s);
        int cyc;
        int nbusy;
        a32 = x; b32 = y; sub32 = s; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        chk("clear_result", res32, 0);
        cyc = 0;
        nbusy = 0;
        while (done32 !== 1'b1 && cyc < 20) begin
            if (busy32 === 1'b1) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done32", done32, 1);
        chk("latency32", cyc, 8);
        chk("busy_cycles32", nbusy, 8);
        chk("busy_at_done32", busy32, 0);
    endtask

    task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int cyc;
        a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done8", done8, 1);
        chk("latency8", cyc, 2);
    endtask

    initial begin
        logic [32:0] ref33;
        logic [31:0] bb32;
        logic [8:0]  ref9;
        logic [7:0]  bb8;
        logic [31:0] ra, rb;
        logic        rs;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_result", res32, 0);
        chk("rst_cout", cout32, 0);
        chk("rst_ovf", ovf32, 0);
        chk("rst_zero", zero32, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        go32(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        chk("t1_result", res32, 32'h0000_0000);
        chk("t1_cout", cout32, 1);
        chk("t1_ovf", ovf32, 0);
        chk("t1_zero", zero32, 1);
        @(posedge clk); #1;
        chk("t1_done_pulse", done32, 0);
        chk("t1_hold", res32, 32'h0000_0000);

        go32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("t2_result", res32, 32'h8000_0000);
        chk("t2_cout", cout32, 0);
        chk("t2_ovf", ovf32, 1);
        chk("t2_zero", zero32, 0);

        go32(32'd5, 32'd7, 1'b1);
        chk("t3_result", res32, 32'hFFFF_FFFE);
        chk("t3_cout", cout32, 0);
        chk("t3_ovf", ovf32, 0);

        go32(32'h8000_0000, 32'd1, 1'b1);
        chk("t4_result", res32, 32'h7FFF_FFFF);
        chk("t4_cout", cout32, 1);
        chk("t4_ovf", ovf32, 1);

        // start pulsed with other operands during every RUN cycle is ignored
        a32 = 32'h10; b32 = 32'h20; sub32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
            start32 = 1'b1;
            @(posedge clk); #1;
        end
        start32 = 1'b0;
        chk("t5_done", done32, 1);
        chk("t5_result", res32, 32'h30);
        // back-to-back acceptance in the DONE cycle: second done 9 cycles on
        go32(32'h100, 32'h200, 1'b0);
        chk("t6_result", res32, 32'h300);

        // reset after the third nibble edge discards the operation
        @(posedge clk); #1;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; sub32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy32, 0);
        chk("mid_rst_done", done32, 0);
        chk("mid_rst_result", res32, 0);
        chk("mid_rst_cout", cout32, 0);
        chk("mid_rst_ovf", ovf32, 0);
        chk("mid_rst_zero", zero32, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst = 1'b0;
            chk("no_done_after_rst", done32, 0);
        end

        go32(32'h1234_5678, 32'h1111_1111, 1'b0);
        chk("t7_result", res32, 32'h2345_6789);
        chk("t7_cout", cout32, 0);
        chk("t7_ovf", ovf32, 0);

        // random regression, 32-bit
        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if (i % 16 == 0) rb = ra;
            bb32  = rs ? ~rb : rb;
            ref33 = {1'b0, ra} + {1'b0, bb32} + 33'(rs);
            go32(ra, rb, rs);
            chk("rnd32_result", res32, ref33[31:0]);
            chk("rnd32_cout", cout32, ref33[32]);
            chk("rnd32_ovf", ovf32, (ra[31] == bb32[31]) && (ref33[31] != ra[31]));
            chk("rnd32_zero", zero32, ref33[31:0] == 32'd0);
        end

        // random regression, 8-bit (two nibbles)
        for (int i = 0; i < 300; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            bb8  = rs ? ~rb[7:0] : rb[7:0];
            ref9 = {1'b0, ra[7:0]} + {1'b0, bb8} + 9'(rs);
            go8(ra[7:0], rb[7:0], rs);
            chk("rnd8_result", res8, ref9[7:0]);
            chk("rnd8_cout", cout8, ref9[8]);
            chk("rnd8_ovf", ovf8, (ra[7] == bb8[7]) && (ref9[7] != ra[7]));
            chk("rnd8_zero", zero8, ref9[7:0] == 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
